pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands.
- Splits the carry chain into STAGES equal slices, one register stage per slice.
- Valid/ready handshake on both sides; sits between operand sources and result consumers in arithmetic datapaths.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_adder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: the carry chain is cut into STAGES equal slices with one register
// stage per slice, operand skew ahead of the chain and sum de-skew behind it.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: illegal WIDTH/STAGES combination");
    end

    logic             w_advance;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Whole pipeline moves together; bubbles are kept so latency is fixed.
    assign w_advance    = !w_out_valid || bus.out_ready;
    assign bus.in_ready = w_advance;
    assign w_b_eff      = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff    = bus.sub ? 1'b1 : bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - (k + 1) * SW;

        logic                w_vld_in;
        logic [SW-1:0]       w_a_sl;
        logic [SW-1:0]       w_b_sl;
        logic                w_c_in;
        logic [SW:0]         w_res;
        logic [(k+1)*SW-1:0] w_sum_next;
        logic                w_load;

        logic                r_vld;
        logic                r_carry;
        logic [(k+1)*SW-1:0] r_sum;

        if (k == 0) begin : g_src
            assign w_vld_in   = bus.in_valid;
            assign w_a_sl     = bus.a[SW-1:0];
            assign w_b_sl     = w_b_eff[SW-1:0];
            assign w_c_in     = w_cin_eff;
            assign w_sum_next = w_res[SW-1:0];
        end else begin : g_src
            assign w_vld_in   = g_stage[k-1].r_vld;
            assign w_a_sl     = g_stage[k-1].g_skew.r_a[SW-1:0];
            assign w_b_sl     = g_stage[k-1].g_skew.r_b[SW-1:0];
            assign w_c_in     = g_stage[k-1].r_carry;
            assign w_sum_next = {w_res[SW-1:0], g_stage[k-1].r_sum};
        end

        assign w_res  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SW{1'b0}}, w_c_in};
        assign w_load = w_advance && w_vld_in;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
            end else if (w_advance) begin
                r_vld <= w_vld_in;
            end
        end

        // Data registers only load real transactions; bubbles leave them untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_load) begin
                r_carry <= w_res[SW];
                r_sum   <= w_sum_next;
            end
        end

        // Operand bits not yet consumed, rebased so bit 0 is the next stage's slice.
        if (REM > 0) begin : g_skew
            logic [REM-1:0] w_a_fwd;
            logic [REM-1:0] w_b_fwd;
            logic [REM-1:0] r_a;
            logic [REM-1:0] r_b;

            if (k == 0) begin : g_fwd
                assign w_a_fwd = bus.a[WIDTH-1:SW];
                assign w_b_fwd = w_b_eff[WIDTH-1:SW];
            end else begin : g_fwd
                assign w_a_fwd = g_stage[k-1].g_skew.r_a[REM+SW-1:SW];
                assign w_b_fwd = g_stage[k-1].g_skew.r_b[REM+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_load) begin
                    r_a <= w_a_fwd;
                    r_b <= w_b_fwd;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= (w_a_sl[SW-1] == w_b_sl[SW-1]) && (w_res[SW-1] != w_a_sl[SW-1]);
                end
            end
        end
    end

    assign w_out_valid   = g_stage[STAGES-1].r_vld;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = g_stage[STAGES-1].r_sum;
    assign bus.cout      = g_stage[STAGES-1].r_carry;
    assign bus.ovf       = g_stage[STAGES-1].g_last.r_ovf;

    property p_out_hold;
        @(posedge clk) disable iff (!rst_n)
        (w_out_valid && !bus.out_ready) |=>
            (w_out_valid && $stable(bus.sum) && $stable(bus.cout) && $stable(bus.ovf));
    endproperty

    a_out_hold: assert property (p_out_hold);
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded checks of pipelined_adder (8-bit/4-stage and 1-bit/1-stage).
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(8)) bus8 ();
    pipelined_adder_if #(.WIDTH(1)) bus1 ();

    pipelined_adder #(.WIDTH(8), .STAGES(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    pipelined_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference result {cout, ovf, sum} for the random stream.
    function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin, input logic sub);
        logic [7:0] b_e;
        logic [8:0] t;
        logic       v;
        b_e = sub ? ~b : b;
        t   = {1'b0, a} + {1'b0, b_e} + {8'd0, (sub ? 1'b1 : cin)};
        v   = (a[7] == b_e[7]) && (t[7] != a[7]);
        return {t[8], v, t[7:0]};
    endfunction

    // One transaction into the 8-bit DUT; edges counted after the accept edge (expect 3).
    task automatic send8(input vec_t v, input string name);
        int         first;
        int         pulses;
        logic [9:0] res;
        first  = -1;
        pulses = 0;
        res    = '0;
        @(negedge clk);
        bus8.a = v.a; bus8.b = v.b; bus8.cin = v.cin; bus8.sub = v.sub;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        #1 check({name, " in_ready"}, 32'(bus8.in_ready), 32'd1);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        for (int e = 0; e < 8; e++) begin
            #1;
            if (bus8.out_valid) begin
                pulses++;
                if (first < 0) begin
                    first = e;
                    res   = {bus8.cout, bus8.ovf, bus8.sum};
                end
            end
            @(negedge clk);
        end
        check({name, " latency"}, 32'(first), 32'd3);
        check({name, " pulses"}, 32'(pulses), 32'd1);
        check({name, " result"}, 32'(res), 32'({v.cout, v.ovf, v.sum}));
    endtask

    vec_t       vecs[8];
    logic [9:0] exp_q[$];
    logic [9:0] frozen;
    logic [9:0] exp_r;
    int         sent;
    int         got;
    int         first1;
    int         pulses1;
    logic [1:0] res1;
    logic       xfer;
    logic       ea;
    logic       eb;
    logic       ec;

    initial begin
        vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h0F, b: 8'hF0, cin: 1'b1, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 8'h05, b: 8'h07, cin: 1'b0, sub: 1'b1, sum: 8'hFE, cout: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h01, cin: 1'b1, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 8'h3C, b: 8'h42, cin: 1'b1, sub: 1'b0, sum: 8'h7F, cout: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 8'h7F, b: 8'hFF, cin: 1'b0, sub: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};

        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus1.out_ready = 1'b1;

        // Reset state; in_ready stays high even with out_ready low.
        #1;
        check("reset out_valid", 32'(bus8.out_valid), 32'd0);
        check("reset sum", 32'({bus8.cout, bus8.ovf, bus8.sum}), 32'd0);
        check("reset in_ready", 32'(bus8.in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("post-reset in_ready", 32'(bus8.in_ready), 32'd1);

        for (int i = 0; i < 8; i++) send8(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 10 back-to-back transactions, out_ready low on cycles 5..8.
        sent = 0;
        got  = 0;
        frozen = '0;
        @(negedge clk);
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        bus8.cin = 1'($urandom_range(0, 1)); bus8.sub = 1'($urandom_range(0, 1));
        bus8.in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            bus8.out_ready = !(cyc >= 5 && cyc <= 8);
            #1;
            check($sformatf("bp in_ready c%0d", cyc), 32'(bus8.in_ready),
                  32'(!(cyc >= 5 && cyc <= 8)));
            if (cyc == 5) frozen = {bus8.cout, bus8.ovf, bus8.sum};
            if (cyc >= 6 && cyc <= 9) begin
                check($sformatf("bp frozen c%0d", cyc),
                      32'({bus8.out_valid, bus8.cout, bus8.ovf, bus8.sum}), 32'({1'b1, frozen}));
            end
            if (bus8.out_valid && bus8.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp unexpected result", 32'(1), 32'(0));
                end else begin
                    exp_r = exp_q.pop_front();
                    check($sformatf("bp result %0d", got), 32'({bus8.cout, bus8.ovf, bus8.sum}),
                          32'(exp_r));
                end
                got++;
            end
            xfer = bus8.in_valid && bus8.in_ready;
            if (xfer) exp_q.push_back(ref_model(bus8.a, bus8.b, bus8.cin, bus8.sub));
            @(negedge clk);
            if (xfer) begin
                sent++;
                if (sent < 10) begin
                    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
                    bus8.cin = 1'($urandom_range(0, 1)); bus8.sub = 1'($urandom_range(0, 1));
                end else begin
                    bus8.in_valid = 1'b0;
                end
            end
        end
        check("bp results received", 32'(got), 32'd10);
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;

        // Reset mid-flight: three in the pipe, first one at the output.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus8.a = 8'h10 + 8'(i); bus8.b = 8'h01; bus8.cin = 1'b0; bus8.sub = 1'b0;
            bus8.in_valid = 1'b1;
            @(negedge clk);
        end
        bus8.in_valid = 1'b0;
        @(negedge clk);
        #1 check("rst pre out_valid", 32'(bus8.out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst sum", 32'({bus8.cout, bus8.ovf, bus8.sum}), 32'd0);
        check("rst in_ready", 32'(bus8.in_ready), 32'd1);
        #1 rst_n = 1'b1;
        pulses1 = 0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            #1 if (bus8.out_valid) pulses1++;
        end
        check("rst stale results", 32'(pulses1), 32'd0);
        send8('{a: 8'h01, b: 8'h01, cin: 1'b0, sub: 1'b0, sum: 8'h02, cout: 1'b0, ovf: 1'b0},
              "post-rst");

        // 1-bit single-stage: full-adder truth table; result right after the accept edge.
        for (int i = 0; i < 8; i++) begin
            ea = i[2]; eb = i[1]; ec = i[0];
            first1  = -1;
            pulses1 = 0;
            res1    = '0;
            @(negedge clk);
            bus1.a = ea; bus1.b = eb; bus1.cin = ec; bus1.sub = 1'b0; bus1.in_valid = 1'b1;
            @(negedge clk);
            bus1.in_valid = 1'b0;
            for (int e = 0; e < 4; e++) begin
                #1;
                if (bus1.out_valid) begin
                    pulses1++;
                    if (first1 < 0) begin
                        first1 = e;
                        res1   = {bus1.cout, bus1.sum[0]};
                    end
                end
                @(negedge clk);
            end
            check($sformatf("fa%0d edges after accept", i), 32'(first1), 32'd0);
            check($sformatf("fa%0d pulses", i), 32'(pulses1), 32'd1);
            check($sformatf("fa%0d cout,sum", i), 32'(res1),
                  32'({(ea & eb) | (ea & ec) | (eb & ec), ea ^ eb ^ ec}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end
endmodule
